// File: rtl/seq_pkg.sv
// seq_pkg: shared serializer types and constants.
// S_PARITY exists only when SEQ_SER_PARITY_EN is defined.
package seq_pkg;
  localparam int SEQ_WIDTH = 8;
  localparam int SEQ_CNT_W = $clog2(SEQ_WIDTH);
`ifdef SEQ_SER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} ser_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA} ser_state_t;
`endif
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/seq_ser_hold.sv
// seq_ser_hold: one-entry holding register between the handshake and the shifter.
module seq_ser_hold import seq_pkg::*; #(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             load,
  output logic             in_ready,
  output logic             hold_full,
  output logic [WIDTH-1:0] hold_data
);
  logic accept, full_next;
  always_comb begin
    accept = in_valid && in_ready;
    full_next = accept || (hold_full && !load);
  end
  // in_ready is a register mirroring !hold_full so it stays low during reset
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      in_ready <= 1'b0;
      hold_data <= '0;
    end else begin
      hold_full <= full_next;
      in_ready <= !full_next;
      if (accept) hold_data <= in_data;
    end
  end
endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel word to one-bit-per-cycle stream with a one-word holding register.
// Define SEQ_SER_PARITY_EN to append an even-parity bit after every word.
module seq_bit_serializer import seq_pkg::*; #(
  parameter int WIDTH = SEQ_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  ser_state_t state;
  logic [WIDTH-1:0] shreg, hold_data;
  logic [CW-1:0] count;
  logic hold_full, load, last_data;
`ifdef SEQ_SER_PARITY_EN
  logic parity;
`endif
  function automatic logic head(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? d[WIDTH-1] : d[0];
  endfunction
  function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? d << 1 : d >> 1;
  endfunction
  seq_ser_hold #(.WIDTH(WIDTH)) u_hold (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .load(load),
    .in_ready(in_ready),
    .hold_full(hold_full),
    .hold_data(hold_data)
  );
  always_comb begin
    last_data = state == S_DATA && count == CW'(WIDTH - 1);
`ifdef SEQ_SER_PARITY_EN
    load = hold_full && (state == S_IDLE || state == S_PARITY);
`else
    load = hold_full && (state == S_IDLE || last_data);
`endif
    busy = hold_full || state != S_IDLE;
  end
  // bit_out always holds the bit being presented; shreg holds the bits still to come
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      shreg <= '0;
      count <= '0;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      word_done <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      parity <= 1'b0;
`endif
    end else if (load) begin
      state <= S_DATA;
      shreg <= tail(hold_data);
      count <= '0;
      bit_out <= head(hold_data);
      bit_valid <= 1'b1;
      word_done <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      parity <= ^hold_data;
`endif
    end else if (state == S_DATA && !last_data) begin
      shreg <= tail(shreg);
      count <= count + 1'b1;
      bit_out <= head(shreg);
`ifdef SEQ_SER_PARITY_EN
      word_done <= 1'b0;
`else
      word_done <= count == CW'(WIDTH - 2);
`endif
`ifdef SEQ_SER_PARITY_EN
    end else if (last_data) begin
      state <= S_PARITY;
      bit_out <= parity;
      word_done <= 1'b1;
`endif
    end else begin
      state <= S_IDLE;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      word_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: randomized bench comparing MSB-first and LSB-first instances
// against a queue-based model of the expected serial stream.
module tb_seq_bit_serializer;
  localparam int W = 8;
`ifdef SEQ_SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  typedef struct {bit bm; bit bl; bit last;} sbit_t;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic rdy_m, out_m, val_m, done_m, busy_m;
  logic rdy_l, out_l, val_l, done_l, busy_l;
  int tests = 0, fails = 0;
  sbit_t out_q[$];
  logic [W-1:0] pend[$];
  bit hold_v = 1'b0, exp_rdy = 1'b0;
  logic [W-1:0] hold_w = '0;
  always #5 clk = ~clk;
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .bit_out(out_m), .bit_valid(val_m), .word_done(done_m), .busy(busy_m)
  );
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .bit_out(out_l), .bit_valid(val_l), .word_done(done_l), .busy(busy_l)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++)
      out_q.push_back('{bm: w[W-1-i], bl: w[i], last: (PAR == 0 && i == W - 1)});
    if (PAR != 0) out_q.push_back('{bm: ^w, bl: ^w, last: 1'b1});
  endtask
  task automatic compare();
    bit v;
    sbit_t h;
    v = out_q.size() > 0;
    h = v ? out_q[0] : '{bm: 1'b0, bl: 1'b0, last: 1'b0};
    check("ready_m", 32'(rdy_m), 32'(exp_rdy));
    check("ready_l", 32'(rdy_l), 32'(exp_rdy));
    check("valid_m", 32'(val_m), 32'(v));
    check("valid_l", 32'(val_l), 32'(v));
    check("bit_m", 32'(out_m), 32'(h.bm));
    check("bit_l", 32'(out_l), 32'(h.bl));
    check("done_m", 32'(done_m), 32'(h.last));
    check("done_l", 32'(done_l), 32'(h.last));
    check("busy_m", 32'(busy_m), 32'(hold_v || v));
    check("busy_l", 32'(busy_l), 32'(hold_v || v));
  endtask
  // check the current cycle, drive the next inputs, then advance the model by one edge
  task automatic cycle(input bit r, input int vprob);
    bit acc;
    compare();
    reset = r;
    in_valid = pend.size() > 0 && int'($urandom_range(99)) < vprob;
    in_data = in_valid ? pend[0] : W'($urandom);
    acc = !r && in_valid && exp_rdy;
    if (r) begin
      out_q.delete();
      hold_v = 1'b0;
      exp_rdy = 1'b0;
    end else begin
      if (out_q.size() > 0) void'(out_q.pop_front());
      if (out_q.size() == 0 && hold_v) begin
        push_word(hold_w);
        hold_v = 1'b0;
      end
      if (acc) begin
        hold_v = 1'b1;
        hold_w = in_data;
        void'(pend.pop_front());
      end
      exp_rdy = !hold_v;
    end
    @(negedge clk);
  endtask
  initial begin
    int n;
    @(negedge clk);
    repeat (2) cycle(1'b1, 0);
    pend.push_back(8'hB5);
    repeat (14) cycle(1'b0, 100);
    pend.push_back(8'h0D);
    repeat (14) cycle(1'b0, 100);
    pend.push_back(8'hA0);
    pend.push_back(8'h0B);
    repeat (26) cycle(1'b0, 100);
    pend.push_back(8'h03);
    repeat (14) cycle(1'b0, 100);
    pend.push_back(8'hFF);
    n = 0;
    while (out_q.size() != W - 3 + PAR && n < 50) begin
      cycle(1'b0, 100);
      n++;
    end
    if (n == 50) check("wait_bit4", 32'(out_q.size()), 32'(W - 3 + PAR));
    cycle(1'b1, 0);
    pend.push_back(8'hB5);
    repeat (16) cycle(1'b0, 100);
    repeat (3000) begin
      if (pend.size() < 3 && $urandom_range(3) == 0) pend.push_back(W'($urandom));
      cycle($urandom_range(399) == 0, $urandom_range(1) != 0 ? 100 : 60);
    end
    repeat (24) cycle(1'b0, 100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Upstream feeder for the sequence detector: accepts parallel words over a valid/ready handshake and emits them as a continuous one-bit-per-cycle serial stream. The stream drives the detector's serial input bit. A one-entry holding register lets back-to-back words stream with no idle gap between them. The block outputs 0 whenever it has no data.

## Interface
- WIDTH, 8: data bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous, active-high; clock clk.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- bit_out  output  1  serial bit; connects to the detector's inp_bit.
- bit_valid  output  1  bit_out carries real data or parity this cycle.
- word_done  output  1  single-cycle pulse in the cycle the final bit of a word is on bit_out.
- busy  output  1  the holding register or the shifter is occupied.

## Operation
- Reset values:
  - in_ready=0 while reset is high; 1 in the first cycle after reset is released.
  - bit_out=0, bit_valid=0, word_done=0, busy=0.
  - Holding register, shifter, bit counter and state are all cleared.
- Handshake:
  - in_ready = !hold_full.
  - A transfer occurs on any edge where in_valid && in_ready.
  - in_data is captured into the holding register; hold_full is set.
  - The upstream may hold in_valid high indefinitely; no combinational path from in_valid to in_ready.
- State machine (shifter) has three states.
  - S_IDLE: bit_out=0, bit_valid=0. If hold_full, load the shifter from the holding register, clear hold_full, set count=0, go to S_DATA.
  - S_DATA: bit_valid=1, bit_out = the current data bit per MSB_FIRST. count increments each cycle.
    - On count==WIDTH-1 with parity built in: go to S_PARITY.
    - On count==WIDTH-1 without parity: the word ends. Reload from hold if hold_full (stay in S_DATA, count=0); otherwise go to S_IDLE.
  - S_PARITY (parity builds only): bit_valid=1, bit_out = even parity, i.e. XOR of all WIDTH data bits, computed at load time. Then reload from hold if hold_full, otherwise go to S_IDLE.
- Simultaneous events:
  - If a load from hold and a new accept land on the same edge, hold_full stays 1 and the holding register takes the new word.
  - in_ready depends on hold_full only, so an accept is not possible while hold is full, even in a load cycle.
- busy = hold_full || state != S_IDLE.
- Reset mid-word: the partial word is dropped. bit_valid=0 in the cycle after the reset edge, and no word_done is produced for the dropped word.

## Timing
- Latency: a word accepted at edge E0 reaches hold after E0 and loads into the shifter at E1. Its first bit appears on bit_out in the cycle after E1 (2 cycles from accept).
- A word occupies WIDTH cycles of bit_valid, or WIDTH+1 cycles with parity.
- Back-to-back: if the next word is in hold before the final-bit edge, bit_valid stays high continuously across the word boundary.
- Throughput is one word per WIDTH (or WIDTH+1) cycles. The holding register refills within 1 cycle of a load, since in_ready rises the cycle after the load.
- word_done is coincident with the last bit: the final data bit, or the parity bit when parity is built in.
- All outputs come directly from registers, with no combinational path from inputs.

## Configuration
- SEQ_SER_PARITY_EN
  - Defined: the S_PARITY state exists and one even-parity bit is appended after every word; word_done moves to the parity cycle.
  - Undefined: no S_PARITY state and no parity logic; a word is exactly WIDTH bits.

## Structure
- Shared package seq_pkg:
  - shifter state enum (S_IDLE, S_DATA, S_PARITY);
  - default WIDTH constant;
  - count width as $clog2(WIDTH).
- Sub-module seq_ser_hold: the one-entry holding register. It covers the accept/load logic and produces hold_full and in_ready.
- The top level instantiates seq_ser_hold and contains the shifter FSM, the bit counter and the parity logic.

## Test plan
- Reset release, WIDTH=8, MSB_FIRST=1: send in_data=8'hB5 -> bit_valid rises 2 cycles after the accept. bit_out reads 1,0,1,1,0,1,0,1, and word_done is high on the 8th bit.
- MSB_FIRST=0: send 8'h0D -> bit_out reads 1,0,1,1,0,0,0,0.
- Back-to-back, in_valid held high with 8'hA0 then 8'h0B -> 16 consecutive cycles of bit_valid=1 with no gap. in_ready is low while hold is full.
- Parity build: 8'hB5 (five ones) -> 8 data bits, then parity bit 1, with word_done on cycle 9. 8'h03 -> parity bit 0.
- Reset asserted on the 4th bit of 8'hFF -> bit_valid=0 the next cycle, busy=0, no word_done. A word sent after release streams normally.
- End-to-end with the sequence detector: stream 8'hB0 MSB-first -> seq_seen is asserted one cycle after the 4th bit is sampled.
